if_stage: RTL
=============

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline, directly upstream of the decode stage (ID).
- Owns the PC register and the next-PC selection driven by ID's `pcsource`/`bpc`/`jpc`/`a`.
- Runs a request/ready handshake to instruction memory and holds the IF/ID pipeline register with a valid bit.
- Honours ID's `stall` and the single branch-delay-slot semantics.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset; first fetch address.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- stall  input  1  from ID; 1 = ID does not consume the IF/ID register this cycle
- pcsource  input  2  from ID: 00 sequential, 01 branch (bpc), 10 register jump (ra), 11 jump (jpc)
- bpc  input  32  branch target from ID
- jpc  input  32  jump target from ID
- ra  input  32  forwarded rs value from ID, used as the jr target
- imem_req  output  1  fetch request; address must stay stable while asserted
- imem_addr  output  32  fetch address (= pc)
- imem_rdata  input  32  instruction word; valid in the cycle imem_ready=1
- imem_ready  input  1  one-cycle completion strobe; ignored when imem_req=0
- pc  output  32  current fetch PC (debug/trace)
- id_inst  output  32  IF/ID instruction; forced to 32'h0 (nop) when id_valid=0
- id_pc4  output  32  IF/ID fetch PC + 4
- id_valid  output  1  IF/ID holds a real instruction

Behaviour:
- Reset (rst=1 at an edge):
  - Register values: pc=PC_RESET, id_valid=0, id_pc4=0, state=FETCH, redir_pend=0, redir_tgt=0, hold_inst=0.
  - Outputs: imem_req=0 while rst=1.
  - A fetch outstanding at reset is abandoned. The memory must tolerate req deassertion.
- Consume event: `take = id_valid & ~stall`.
- Redirect event: `redir = take & (pcsource != 2'b00)`.
  - Target is muxed by pcsource: 01→bpc, 10→ra, 11→jpc.
  - pcsource is ignored unless take=1.
- Slot free: `free = ~id_valid | take`.
- FSM:
  - FETCH: imem_req=1, imem_addr=pc.
    - imem_ready & free: id_inst←imem_rdata, id_pc4←pc+4, id_valid←1, pc←next; stay in FETCH.
    - imem_ready & ~free: hold_inst←imem_rdata; go to HOLD. pc is unchanged.
    - ~imem_ready & take: id_valid←0 (bubble).
  - HOLD: imem_req=0.
    - On take: id_inst←hold_inst, id_pc4←pc+4, id_valid←1, pc←next; go to FETCH.
- next-PC priority:
  1. redir this cycle → target
  2. else redir_pend → redir_tgt, and clear redir_pend
  3. else pc+4
- Redirect without a capture in the same cycle: redir_pend←1, redir_tgt←target. It is applied at the next capture.
- Delay slot: when a branch sits in ID, pc already equals branch address + 4. That instruction is always delivered; the target follows it. One-cycle fetch latency with no stall gives branch, slot, target on consecutive ID cycles.
- Redirect while redir_pend=1 is illegal (no new instruction can reach ID before the pending redirect is applied). The bench asserts it never occurs.
- Arithmetic: pc+4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 0. Targets are not realigned; bits [1:0] pass through.
- Steady-state throughput: one instruction per cycle when imem_ready is held high and stall=0. Latency from address issue to id_valid is 1 edge after imem_ready.

Decomposition:
- Shared package `pipeline_pkg` holds:
  - PCSRC_SEQ/PCSRC_BR/PCSRC_JR/PCSRC_J = 2'b00/01/10/11
  - NOP_INST = 32'h0
  - IF FSM state encoding (FETCH=0, HOLD=1)
- Reuse the existing `mux32_4_1` for target selection; pc+4 goes on input 00.
- No other sub-module; the FSM, PC and IF/ID register stay in if_stage.

Test Plan:
1. Sequential fetch: rst high 2 cycles, then low; imem_ready=1, stall=0 → imem_addr 0,4,8,C on successive cycles; id_pc4 4,8,C; id_valid rises one cycle after the first req.
2. Branch with delay slot: ready=1; when id_pc4=0xC drive pcsource=01, bpc=0x40 → id_pc4 sequence 0xC, 0x10 (slot), 0x44; imem_addr sequence 0xC, 0x40.
3. Redirect during slow fetch: memory latency 3 cycles; pcsource=11, jpc=0x100 asserted while slot 0x10 is outstanding → slot captured with id_pc4=0x14, then imem_addr=0x100; redir_pend clears.
4. Stall with hold: ready=1, stall=1 for 2 cycles while id_valid=1 → FSM in HOLD, imem_req=0, id_inst stable. After release, the held word appears next cycle, then fetch resumes at pc+4.
5. jr and empty slot: ID empty, stall=0, ready=0 → id_valid=0, id_inst=0. Then pcsource=10, ra=0x200 on a valid instruction → next fetch imem_addr=0x200 after the slot.
6. Reset mid-fetch: rst pulsed while req outstanding → next cycle pc=PC_RESET, id_valid=0, imem_req=0; the following cycle req=1 at PC_RESET.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline stages.
//   PCSRC_*  : next-PC source codes driven by ID on pcsource
//   NOP_INST : instruction word presented to ID when the IF/ID slot is empty
//   if_state_e : instruction-fetch FSM encoding (FETCH=0, HOLD=1)
//   pc_plus4 : sequential successor of a PC, 32-bit modulo
package pipeline_pkg;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JR  = 2'b10;
  localparam logic [1:0] PCSRC_J   = 2'b11;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } if_state_e;

  function automatic logic [31:0] pc_plus4(input logic [31:0] p);
    return p + 32'd4;
  endfunction

endpackage

// File: rtl/mux32_4_1.sv
// Four-input word multiplexer.
//   a0..a3 : data inputs, selected by sel = 00..11
//   sel    : select
//   y      : selected word
module mux32_4_1 #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] a1,
  input  logic [DATA_W-1:0] a2,
  input  logic [DATA_W-1:0] a3,
  input  logic [1:0]        sel,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = a0;
    case (sel)
      2'b00:   y = a0;
      2'b01:   y = a1;
      2'b10:   y = a2;
      default: y = a3;
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage. Owns the PC, issues fetches to instruction memory
// with a req/ready handshake and holds the IF/ID register feeding decode.
//   clk, rst               : clock, synchronous active-high reset
//   stall                  : ID does not consume the IF/ID register this cycle
//   pcsource, bpc, jpc, ra : next-PC selection from ID (00 seq, 01 bpc, 10 ra, 11 jpc)
//   imem_req, imem_addr    : fetch request and address (address = pc, stable while req)
//   imem_rdata, imem_ready : returned word and one-cycle completion strobe
//   pc                     : current fetch PC
//   id_inst, id_pc4, id_valid : IF/ID register (id_inst reads as nop when empty)
module if_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic [31:0] ra,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc4,
  output logic        id_valid
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] pc4;
  logic [31:0] target;
  logic [31:0] next_pc;
  logic [1:0]  tgt_sel;
  logic        redir_pend_q;
  logic [31:0] redir_tgt_q;
  logic [31:0] hold_inst_q;
  logic        take, redir, free;
  logic        capture, from_hold, hold_load, req_c;

  logic [31:0] inst_p1;
  logic [31:0] pc4_p1;
  logic        vld_p1;

  assign take  = vld_p1 & ~stall;
  assign redir = take & (pcsource != PCSRC_SEQ);
  assign free  = ~vld_p1 | take;
  assign pc4   = pc_plus4(pc_q);

  // pcsource only counts when ID actually consumes; otherwise the mux
  // falls back to the sequential input.
  assign tgt_sel = take ? pcsource : PCSRC_SEQ;

  mux32_4_1 #(.DATA_W(32)) u_tgt_mux (
    .a0  (pc4),
    .a1  (bpc),
    .a2  (ra),
    .a3  (jpc),
    .sel (tgt_sel),
    .y   (target)
  );

  // A redirect seen now wins; a redirect seen earlier (while the delay
  // slot was still in flight) is applied at the next capture.
  assign next_pc = redir        ? target      :
                   redir_pend_q ? redir_tgt_q : pc4;

  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    from_hold = 1'b0;
    hold_load = 1'b0;
    req_c     = 1'b0;
    case (state_q)
      FETCH: begin
        req_c = 1'b1;
        if (imem_ready && free) begin
          capture = 1'b1;
        end else if (imem_ready) begin
          hold_load = 1'b1;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (take) begin
          capture   = 1'b1;
          from_hold = 1'b1;
          state_d   = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= PC_RESET;
      vld_p1       <= 1'b0;
      pc4_p1       <= 32'h0;
      redir_pend_q <= 1'b0;
      redir_tgt_q  <= 32'h0;
      hold_inst_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      if (hold_load) begin
        hold_inst_q <= imem_rdata;
      end
      if (capture) begin
        pc_q         <= next_pc;
        vld_p1       <= 1'b1;
        pc4_p1       <= pc4;
        redir_pend_q <= 1'b0;
      end else begin
        if (take) begin
          vld_p1 <= 1'b0;
        end
        if (redir) begin
          redir_pend_q <= 1'b1;
          redir_tgt_q  <= target;
        end
      end
    end
  end

  // ---- IF -> ID boundary: instruction word, qualified by vld_p1 ----
  always_ff @(posedge clk) begin
    if (capture) begin
      inst_p1 <= from_hold ? hold_inst_q : imem_rdata;
    end
  end

  assign imem_req  = req_c & ~rst;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign id_inst   = vld_p1 ? inst_p1 : NOP_INST;
  assign id_pc4    = pc4_p1;
  assign id_valid  = vld_p1;

endmodule
